// File: rtl/if_prefetch_stage.sv
// ---------------------------------------------------------------------------
// if_prefetch_stage
//
// Instruction-fetch stage. It issues sequential fetches ahead of decode,
// keeps up to MAX_OUTSTANDING requests in flight and buffers the returned
// instructions in an IBUF_DEPTH-entry queue. A redirect from an exception,
// ertn or branch restarts fetch at a new pc. Responses that still belong to
// the old stream are counted off in discard_cnt and dropped.
//
// Optional feature macro: IF_ADEF_EN
//   defined   : a misaligned fetch_pc issues no request. Instead it enqueues
//               a single {adef=1, inst=0, pc} entry and then fetch stalls
//               until the next redirect.
//   undefined : fetch_pc[1:0] is ignored and adef is always 0.
//
// Ports
//   clk, resetn            clock, synchronous active-low reset
//   inst_sram_*            SRAM-like fetch port. Read only, word size.
//   ds_allowin             decode can take the queue head this cycle
//   br_stall               hold off new requests
//   br_taken/br_target     branch redirect pulse and target
//   wb_ex/ex_entry         exception redirect pulse and entry
//   ertn_flush/ertn_entry  ertn redirect pulse and return address
//   fs_to_ds_valid/bus     queue head {adef, inst[31:0], pc[31:0]}
//
// Handshakes: a request transfers on a cycle with inst_sram_req &
// inst_sram_addr_ok. Each inst_sram_data_ok returns one response, in
// request order. The queue head transfers on fs_to_ds_valid & ds_allowin.
// Once raised, req only falls without a transfer in a redirect or br_stall
// cycle.
// ---------------------------------------------------------------------------
module if_prefetch_stage #(
  parameter logic [31:0] RESET_PC        = 32'h1c000000,
  parameter int          MAX_OUTSTANDING = 2,
  parameter int          IBUF_DEPTH      = 4
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  input  logic        ds_allowin,
  input  logic        br_stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        wb_ex,
  input  logic [31:0] ex_entry,
  input  logic        ertn_flush,
  input  logic [31:0] ertn_entry,
  output logic        fs_to_ds_valid,
  output logic [64:0] fs_to_ds_bus
);

  localparam int CW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int QW  = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;
  localparam int QCW = $clog2(IBUF_DEPTH + 1);

  localparam logic [CW-1:0]  MAX_OUT_C = CW'(MAX_OUTSTANDING);
  localparam logic [QCW-1:0] DEPTH_C   = QCW'(IBUF_DEPTH);
  localparam logic [QCW:0]   DEPTH_W_C = (QCW+1)'(IBUF_DEPTH);

  logic [31:0]    fetch_pc;
  logic [CW-1:0]  out_cnt;
  logic [CW-1:0]  discard_cnt;
  logic [CW-1:0]  live_cnt;
  logic [31:0]    pc_fifo [MAX_OUTSTANDING];
  logic [PW-1:0]  pf_wr, pf_rd;
  logic [64:0]    q_mem [IBUF_DEPTH];
  logic [QW-1:0]  q_wr, q_rd;
  logic [QCW-1:0] q_count;
  logic [QCW:0]   credit_sum;

  logic        redirect;
  logic [31:0] redirect_pc;
  logic        accept;
  logic        resp_keep;
  logic        adef_push;
  logic        issue_block;
  logic        push;
  logic        pop;
  logic [64:0] push_entry;

  function automatic logic [PW-1:0] pf_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [QW-1:0] q_inc(input logic [QW-1:0] p);
    return (p == QW'(IBUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Redirect source priority: exception over ertn over branch.
  always_comb begin
    redirect    = wb_ex | ertn_flush | br_taken;
    redirect_pc = br_target;
    if (ertn_flush) redirect_pc = ertn_entry;
    if (wb_ex)      redirect_pc = ex_entry;
  end

  // Only live (not-to-be-discarded) outstanding requests reserve queue
  // space. A request can therefore only issue when its response is sure
  // to find a free entry, and rdata never needs a holding register.
  assign live_cnt   = out_cnt - discard_cnt;
  assign credit_sum = (QCW+1)'(live_cnt) + (QCW+1)'(q_count);

`ifdef IF_ADEF_EN
  logic adef_hold;
  logic misaligned;
  assign misaligned  = fetch_pc[1:0] != 2'b00;
  assign issue_block = misaligned | adef_hold;
  // The fault entry waits until the old stream has drained so that it
  // reaches decode in program order.
  assign adef_push   = misaligned & ~adef_hold & ~redirect &
                       (out_cnt == '0) & (q_count < DEPTH_C);
`else
  assign issue_block = 1'b0;
  assign adef_push   = 1'b0;
`endif

  assign inst_sram_req   = resetn & ~redirect & ~br_stall & ~issue_block &
                           (out_cnt < MAX_OUT_C) & (credit_sum < DEPTH_W_C);
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'b10;
  assign inst_sram_wstrb = 4'b0000;
  assign inst_sram_addr  = fetch_pc;
  assign inst_sram_wdata = 32'h0;

  assign accept    = inst_sram_req & inst_sram_addr_ok;
  // A response arriving in a redirect cycle belongs to the old stream.
  assign resp_keep = inst_sram_data_ok & ~redirect & (discard_cnt == '0);
  assign push      = resp_keep | adef_push;
  assign pop       = fs_to_ds_valid & ds_allowin;

  always_comb begin
    push_entry = {1'b0, inst_sram_rdata, pc_fifo[pf_rd]};
    if (adef_push) push_entry = {1'b1, 32'h0, fetch_pc};
  end

  assign fs_to_ds_valid = q_count != '0;
  assign fs_to_ds_bus   = fs_to_ds_valid ? q_mem[q_rd] : '0;

  // Storage arrays carry no reset; their pointers and counts do.
  always_ff @(posedge clk) begin
    if (resetn && accept) pc_fifo[pf_wr] <= fetch_pc;
    if (resetn && !redirect && push) q_mem[q_wr] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      fetch_pc    <= RESET_PC;
      out_cnt     <= '0;
      discard_cnt <= '0;
      pf_wr       <= '0;
      pf_rd       <= '0;
      q_wr        <= '0;
      q_rd        <= '0;
      q_count     <= '0;
    end else begin
      if (redirect)    fetch_pc <= redirect_pc;
      else if (accept) fetch_pc <= fetch_pc + 32'd4;

      // The pc FIFO is never flushed. Discarded responses still pop it,
      // which keeps it aligned with the response order.
      if (accept)            pf_wr <= pf_inc(pf_wr);
      if (inst_sram_data_ok) pf_rd <= pf_inc(pf_rd);

      out_cnt <= out_cnt + CW'(accept) - CW'(inst_sram_data_ok);

      // On a redirect every outstanding request becomes a discard. That is
      // discard_cnt plus the live requests, minus one answered right now.
      // The count therefore never exceeds out_cnt.
      if (redirect)
        discard_cnt <= out_cnt - CW'(inst_sram_data_ok);
      else if (inst_sram_data_ok && discard_cnt != '0)
        discard_cnt <= discard_cnt - 1'b1;

      if (redirect) begin
        q_wr    <= '0;
        q_rd    <= '0;
        q_count <= '0;
      end else begin
        if (push) q_wr <= q_inc(q_wr);
        if (pop)  q_rd <= q_inc(q_rd);
        q_count <= q_count + QCW'(push) - QCW'(pop);
      end
    end
  end

`ifdef IF_ADEF_EN
  always_ff @(posedge clk) begin
    if (!resetn || redirect) adef_hold <= 1'b0;
    else if (adef_push)      adef_hold <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_if_prefetch_stage.sv
// ---------------------------------------------------------------------------
// tb_if_prefetch_stage
//
// Directed bench for if_prefetch_stage (default parameters).
// The bench models the SRAM as a queue of accepted addresses, each marked
// live or dead. Every live response pushes the instruction that decode
// should receive onto exp_q. Every decode transfer pops exp_q and compares.
// ---------------------------------------------------------------------------
module tb_if_prefetch_stage;

  localparam logic [31:0] RESET_PC = 32'h1c000000;
  localparam int MAXO  = 2;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        ds_allowin;
  logic        br_stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        wb_ex;
  logic [31:0] ex_entry;
  logic        ertn_flush;
  logic [31:0] ertn_entry;
  logic        fs_to_ds_valid;
  logic [64:0] fs_to_ds_bus;

  if_prefetch_stage #(
    .RESET_PC(RESET_PC), .MAX_OUTSTANDING(MAXO), .IBUF_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata), .ds_allowin(ds_allowin),
    .br_stall(br_stall), .br_taken(br_taken), .br_target(br_target),
    .wb_ex(wb_ex), .ex_entry(ex_entry), .ertn_flush(ertn_flush),
    .ertn_entry(ertn_entry), .fs_to_ds_valid(fs_to_ds_valid),
    .fs_to_ds_bus(fs_to_ds_bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [64:0] exp_q[$];
  logic [31:0] pend_addr_q[$];
  bit          pend_live_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  bit          resp_en;
  bit          prev_stalled;
  logic [31:0] prev_addr;
  bit          exp_acc_valid;
  logic [31:0] exp_acc_addr;
  int          valid_cnt;
  int          waited;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h3c5a0f96;
  endfunction

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("check %s did not match", tag);
    end
  endtask

  // One clock cycle. Outputs are sampled at the negedge. The responder
  // drives data_ok/rdata just after the posedge.
  task automatic cyc();
    logic        redir;
    logic [31:0] a;
    bit          l;
    @(negedge clk);
    redir = wb_ex | ertn_flush | br_taken;
    if (resetn) begin
      if (prev_stalled && !redir && !br_stall) begin
        chk("req_hold", 65'(inst_sram_req), 65'(1'b1));
        chk("addr_hold", 65'(inst_sram_addr), 65'(prev_addr));
      end
      if (redir) chk("req_in_redirect", 65'(inst_sram_req), 65'(1'b0));
      if (fs_to_ds_valid && ds_allowin) begin
        if (exp_q.size() == 0) chk("unexpected_valid", 65'(fs_to_ds_valid), 65'(1'b0));
        else chk("ds_bus", fs_to_ds_bus, exp_q.pop_front());
      end
      if (inst_sram_data_ok) begin
        a = pend_addr_q.pop_front();
        l = pend_live_q.pop_front();
        if (l && !redir) exp_q.push_back({1'b0, mem_data(a), a});
      end
      if (redir) begin
        exp_q.delete();
        foreach (pend_live_q[i]) pend_live_q[i] = 1'b0;
      end
      if (inst_sram_req && inst_sram_addr_ok) begin
        if (exp_acc_valid) begin
          chk("redirect_target", 65'(inst_sram_addr), 65'(exp_acc_addr));
          exp_acc_valid = 1'b0;
        end
        pend_addr_q.push_back(inst_sram_addr);
        pend_live_q.push_back(1'b1);
      end
      prev_stalled = inst_sram_req & ~inst_sram_addr_ok;
      prev_addr    = inst_sram_addr;
    end else begin
      prev_stalled = 1'b0;
    end
    @(posedge clk);
    #1;
    inst_sram_data_ok = resetn && resp_en && (pend_addr_q.size() > 0);
    inst_sram_rdata   = inst_sram_data_ok ? mem_data(pend_addr_q[0]) : 32'h0;
  endtask

  // Bounded wait for the queue head to become valid.
  task automatic wait_valid(input string tag);
    waited = 0;
    while (!fs_to_ds_valid && waited < 20) begin
      cyc();
      waited++;
    end
    chk(tag, 65'(fs_to_ds_valid), 65'(1'b1));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    resetn = 1'b0; inst_sram_addr_ok = 1'b1; inst_sram_data_ok = 1'b0;
    inst_sram_rdata = 32'h0; ds_allowin = 1'b1; br_stall = 1'b0;
    br_taken = 1'b0; br_target = 32'h0; wb_ex = 1'b0; ex_entry = 32'h0;
    ertn_flush = 1'b0; ertn_entry = 32'h0; resp_en = 1'b1;
    prev_stalled = 1'b0; prev_addr = 32'h0; exp_acc_valid = 1'b0;
    exp_acc_addr = 32'h0;

    // Reset state.
    repeat (3) cyc();
    chk("rst_req", 65'(inst_sram_req), 65'(1'b0));
    chk("rst_valid", 65'(fs_to_ds_valid), 65'(1'b0));
    chk("rst_bus", fs_to_ds_bus, 65'h0);
    chk("const_fields", 65'({inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata}),
        65'({1'b0, 2'b10, 4'b0000, 32'h0}));

    // Streaming: the first request follows reset release immediately.
    resetn = 1'b1;
    #1;
    chk("first_req", 65'(inst_sram_req), 65'(1'b1));
    chk("first_addr", 65'(inst_sram_addr), 65'(RESET_PC));
    repeat (4) cyc();
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("no_bubble", 65'(fs_to_ds_valid), 65'(1'b1));
    end

    // Decode backpressure: the queue fills and req stays low.
    ds_allowin = 1'b0;
    repeat (10) cyc();
    chk("bp_req_low", 65'(inst_sram_req), 65'(1'b0));
    chk("bp_valid", 65'(fs_to_ds_valid), 65'(1'b1));
    inst_sram_addr_ok = 1'b0;
    ds_allowin = 1'b1;
    valid_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (fs_to_ds_valid) valid_cnt++;
      cyc();
    end
    chk("bp_drain_count", 65'(valid_cnt), 65'(DEPTH));

    // Branch while two responses are pending.
    resp_en = 1'b0;
    inst_sram_addr_ok = 1'b1;
    repeat (3) cyc();
    chk("two_out_req_low", 65'(inst_sram_req), 65'(1'b0));
    br_target = 32'h1c000100; br_taken = 1'b1;
    exp_acc_valid = 1'b1; exp_acc_addr = 32'h1c000100;
    cyc();
    br_taken = 1'b0;
    resp_en = 1'b1;
    wait_valid("br_wait");
    chk("br_first_pc", 65'(fs_to_ds_bus[31:0]), 65'(32'h1c000100));
    chk("br_first_inst", 65'(fs_to_ds_bus[63:32]), 65'(mem_data(32'h1c000100)));
    repeat (4) cyc();

    // Redirect priority: exception beats a same-cycle branch.
    wb_ex = 1'b1; ex_entry = 32'h1c008000;
    br_taken = 1'b1; br_target = 32'h1c000200;
    exp_acc_valid = 1'b1; exp_acc_addr = 32'h1c008000;
    cyc();
    wb_ex = 1'b0; br_taken = 1'b0;
    wait_valid("prio_wait");
    chk("prio_pc", 65'(fs_to_ds_bus[31:0]), 65'(32'h1c008000));
    repeat (4) cyc();

    // ertn_flush coincides with a response: that response is dropped.
    waited = 0;
    while (!inst_sram_data_ok && waited < 10) begin
      cyc();
      waited++;
    end
    ertn_flush = 1'b1; ertn_entry = 32'h1c002000;
    exp_acc_valid = 1'b1; exp_acc_addr = 32'h1c002000;
    cyc();
    ertn_flush = 1'b0;
    wait_valid("ertn_wait");
    chk("ertn_pc", 65'(fs_to_ds_bus[31:0]), 65'(32'h1c002000));
    repeat (4) cyc();
    chk("discard_zero", 65'(dut.discard_cnt), 65'h0);

    // Randomised traffic with backpressure, addr/data stalls and br_stall.
    for (int i = 0; i < 60; i++) begin
      ds_allowin        = 1'($urandom_range(0, 1));
      inst_sram_addr_ok = 1'($urandom_range(0, 1));
      resp_en           = 1'($urandom_range(0, 1));
      br_stall          = ($urandom_range(0, 7) == 0);
      cyc();
    end
    ds_allowin = 1'b1; inst_sram_addr_ok = 1'b1; resp_en = 1'b1; br_stall = 1'b0;
    repeat (6) cyc();

    // Misaligned branch target.
    br_target = 32'h1c000102; br_taken = 1'b1;
`ifndef IF_ADEF_EN
    exp_acc_valid = 1'b1; exp_acc_addr = 32'h1c000102;
`endif
    cyc();
    br_taken = 1'b0;
`ifdef IF_ADEF_EN
    exp_q.push_back({1'b1, 32'h0, 32'h1c000102});
    cyc();
    chk("adef_no_req", 65'(inst_sram_req), 65'(1'b0));
    wait_valid("adef_wait");
    chk("adef_entry", fs_to_ds_bus, {1'b1, 32'h0, 32'h1c000102});
    repeat (5) cyc();
    chk("adef_hold_req", 65'(inst_sram_req), 65'(1'b0));
    chk("adef_single", 65'(fs_to_ds_valid), 65'(1'b0));
`else
    wait_valid("mis_wait");
    chk("mis_pc", 65'(fs_to_ds_bus[31:0]), 65'(32'h1c000102));
    repeat (4) cyc();
`endif

    // Reset in mid-operation: no stale responses are delivered afterwards.
    resetn = 1'b0;
    inst_sram_data_ok = 1'b0;
    pend_addr_q.delete(); pend_live_q.delete(); exp_q.delete();
    exp_acc_valid = 1'b0;
    repeat (2) cyc();
    chk("rst2_valid", 65'(fs_to_ds_valid), 65'(1'b0));
    chk("rst2_req", 65'(inst_sram_req), 65'(1'b0));
    resetn = 1'b1;
    exp_acc_valid = 1'b1; exp_acc_addr = RESET_PC;
    wait_valid("rst2_wait");
    chk("rst2_pc", 65'(fs_to_ds_bus[31:0]), 65'(RESET_PC));

    // Drain: every expected instruction must have been delivered.
    inst_sram_addr_ok = 1'b0;
    repeat (15) cyc();
    chk("final_drain", 65'(exp_q.size()), 65'h0);
    chk("final_valid", 65'(fs_to_ds_valid), 65'(1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
